// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter/sequencer sharing one floating-point add/subtract unit
// among N requesters, each of which sees a private unit with the same handshake.
//
// state | meaning
// IDLE  | waiting for a pending request; picks the round-robin winner
// ISSUE | winner's operands are on au_*; au_beg pulses on the way out
// WAIT  | unit is computing; result captured when au_ready rises
// DONE  | result presented to the winner until it acknowledges
module fp_addsub_arbiter #(
  parameter  int N  = 3,
  parameter  int W  = 32,
  localparam int GW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_beg,
  input  logic [N-1:0]   req_op,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N-1:0]   req_ack,
  output logic [N-1:0]   req_ready,
  output logic [W-1:0]   req_result,
  output logic [N-1:0]   req_pending,
  output logic [GW-1:0]  grant_id,
  output logic           err_overrun,
  output logic           au_beg,
  output logic           au_op,
  output logic [W-1:0]   au_a,
  output logic [W-1:0]   au_b,
  output logic           au_ack,
  input  logic           au_ready,
  input  logic [W-1:0]   au_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [N-1:0]  pend;
  logic [N-1:0]  op_q;
  logic [W-1:0]  a_q [N];
  logic [W-1:0]  b_q [N];
  logic [GW-1:0] last;

  logic [N-1:0]  grant_oh;
  logic          done_ack;
  logic [N-1:0]  clr;
  logic [N-1:0]  cap;
  logic [N-1:0]  ovr_hit;
  logic [N-1:0]  above;
  logic [N-1:0]  pick;
  logic [GW-1:0] win;
  logic          win_vld;

  assign grant_oh    = N'(1) << grant_id;
  assign done_ack    = (state == DONE) && |(req_ack & grant_oh);
  assign au_ack      = done_ack;
  assign req_pending = pend;

  // A new start in the same cycle as the clear re-arms the slot: set wins.
  assign clr     = done_ack ? grant_oh : '0;
  assign cap     = req_beg & (~pend | clr);
  assign ovr_hit = req_beg & pend & ~clr;

  // Round robin: prefer pending requesters above 'last', else wrap to the lowest.
  always_comb begin
    above   = pend & ~((N'(2) << last) - N'(1));
    pick    = (above != '0) ? above : pend;
    win     = '0;
    win_vld = |pend;
    for (int k = N - 1; k >= 0; k--) begin
      if (pick[k]) win = GW'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= '0;
      op_q        <= '0;
      err_overrun <= 1'b0;
      for (int i = 0; i < N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      pend        <= (pend & ~clr) | cap;
      err_overrun <= err_overrun | (|ovr_hit);
      for (int i = 0; i < N; i++) begin
        if (cap[i]) begin
          op_q[i] <= req_op[i];
          a_q[i]  <= req_a[i*W +: W];
          b_q[i]  <= req_b[i*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= GW'(N - 1);
      grant_id   <= '0;
      au_beg     <= 1'b0;
      au_op      <= 1'b0;
      au_a       <= '0;
      au_b       <= '0;
      req_ready  <= '0;
      req_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          au_beg <= 1'b0;
          if (win_vld) begin
            grant_id <= win;
            au_op    <= op_q[win];
            au_a     <= a_q[win];
            au_b     <= b_q[win];
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          au_beg <= 1'b1;
          state  <= WAIT;
        end
        WAIT: begin
          au_beg <= 1'b0;
          if (au_ready) begin
            req_result <= au_result;
            req_ready  <= grant_oh;
            state      <= DONE;
          end
        end
        DONE: begin
          au_beg <= 1'b0;
          if (done_ack) begin
            req_ready <= '0;
            last      <= grant_id;
            state     <= IDLE;
          end
        end
        default: begin
          au_beg    <= 1'b0;
          req_ready <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fp_addsub_arbiter.md
# fp_addsub_arbiter

Round-robin arbiter and sequencer that shares one floating-point add/subtract unit among `N` requesters, e.g. the CORDIC controller, the top-level FPU add path and a spare client. It sits between the requesters' `beg/ready/ack` handshakes and the single unit's `beg_add_subt/ready_add_subt/ack_add_subt` handshake. Each requester sees a private add/subtract unit with the same handshake protocol.

## Interface
Parameters:
- `N`, 3: number of requesters (2..4).
- `W`, 32: operand/result width.
- `GW` (localparam): `$clog2(N)`, width of `grant_id`.

Ports:
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_beg` in N: per-requester one-cycle start pulse.
- `req_op` in N: per-requester operation, 0 = add, 1 = subtract; sampled with `req_beg`.
- `req_a` in N*W: packed operand A; requester i at `[i*W +: W]`; sampled with `req_beg`.
- `req_b` in N*W: packed operand B; same packing as `req_a`.
- `req_ack` in N: requester i has taken its result.
- `req_ready` out N: result valid for requester i (level).
- `req_result` out W: result, broadcast to all requesters; valid only where `req_ready[i]` is high.
- `req_pending` out N: request latched and not yet acknowledged.
- `grant_id` out GW: requester currently owning the unit.
- `err_overrun` out 1: sticky; set when `req_beg[i]` arrives while `req_pending[i]` is already 1.
- `au_beg` out 1: start pulse to the unit.
- `au_op` out 1: operation to the unit.
- `au_a` out W: operand A to the unit.
- `au_b` out W: operand B to the unit.
- `au_ack` out 1: result-consumed pulse to the unit.
- `au_ready` in 1: unit result valid.
- `au_result` in W: unit result.

## Operation
- Request capture. `req_beg[i]` with `req_pending[i]`=0 sets `pend[i]` and captures `req_op[i]`, `req_a[i]` and `req_b[i]` into per-requester registers. Requesters do not need to hold operands after the pulse.
- Overrun. `req_beg[i]` with `pend[i]`=1 is ignored (captured data is unchanged) and sets `err_overrun`.
- FSM states and transitions:
  - IDLE: if any `pend` is set, select a winner round-robin starting at `last+1 mod N`. Load `grant_id`, `au_op`, `au_a` and `au_b` from the winner's capture registers. Go to ISSUE.
  - ISSUE: `au_beg`=1 for exactly this cycle. Go to WAIT.
  - WAIT: on `au_ready`=1, register `au_result` into `res_reg` and go to DONE. Otherwise stay in WAIT; there is no timeout.
  - DONE: `req_ready[grant_id]`=1 and `req_result`=`res_reg`. On `req_ack[grant_id]`=1:
    - `au_ack`=1 for this single cycle (combinational from the state and the ack);
    - clear `pend[grant_id]`;
    - set `last`=`grant_id`;
    - go to IDLE.
- `req_ack` from a non-granted requester, or any `req_ack` outside DONE, is ignored.
- Set wins over clear. If `req_beg[i]` arrives in the same cycle DONE clears `pend[i]`, `pend[i]` stays 1 with the new operands captured. This is not an overrun.
- Operand registers `au_a`, `au_b` and `au_op` hold their values from IDLE-exit until the next grant.
- Encoding of invalid FSM state: return to IDLE.

## Timing
- Reset state (asynchronous, while `rst_n`=0):
  - FSM = IDLE, `pend`=0, `last`=N-1 (requester 0 has first priority);
  - all outputs 0, including `grant_id`, `req_result`, `au_a`, `au_b` and `err_overrun`.
- Latency, uncontended. `req_beg` is sampled at edge E. IDLE decides during the cycle after E. `au_beg` is high in the cycle following edge E+2.
- After `au_ready` is sampled high at edge R, `req_ready` is high from edge R onward.
- Turnaround. `req_ack` sampled at edge K puts the FSM in IDLE from K. The next grant's `au_beg` is high from edge K+2.
- Minimum cycle count per operation is 4 (IDLE, ISSUE, WAIT ≥ 1, DONE ≥ 1), plus unit latency.
- Reset mid-operation returns the block to IDLE immediately and discards all pending requests. No `au_ack` is issued; the add/subtract unit must be reset together with this block.

## Test plan
- Single request: requester 1 issues `req_beg` with a=`0x3F800000`, b=`0x40000000`, op=0 → `au_beg` one cycle at E+2 with those operands. Unit returns `0x40400000` → `req_ready`=`3'b010` and `req_result`=`0x40400000`. After `req_ack[1]`, `au_ack` is a single pulse and `req_pending`=0.
- Contention: all three requesters issue `req_beg` in the same cycle → grant order 0, 1, 2. `au_beg` occurs exactly three times and each `req_ready` is one-hot in turn.
- Fairness: requester 0 re-requests immediately after every ack while requester 2 is pending → grants alternate 0, 2, 0. Requester 2 waits at most one service.
- Held ack: `req_ack` is delayed 10 cycles → `req_ready` and `req_result` stay stable and `au_ack` stays 0 for all 10 cycles. A stray `req_ack` on a non-granted requester has no effect.
- Overrun and set-wins:
  - a second `req_beg[2]` while pending → `err_overrun`=1 (sticky) and the original operands are used;
  - `req_beg[2]` in the ack cycle → `req_pending[2]` remains 1 and the new operands are issued next.
- Reset mid-WAIT: drop `rst_n` while `au_ready`=0 → all outputs are 0 at once, with no `au_ack`. After release, a new request completes normally starting from requester 0 priority.
